regfile_dump: RTL and testbench



---
 rtl/regfile_dump.sv | 90 +++++++++
 tb/tb_regfile_dump.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug read-out engine for the 32x32 MIPS register file: walks FIRST_REG..LAST_REG
// through one read port and streams {index, data} beats over valid/ready.
module regfile_dump #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_index,
   output logic [31:0] out_data
);

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} stateT;

   localparam logic [4:0] firstIdx = 5'(FIRST_REG);
   localparam logic [4:0] lastIdx  = 5'(LAST_REG);

   stateT      state;
   stateT      stateNext;
   logic [4:0] idx;
   logic [4:0] idxNext;
   logic       capture;

   // Next-state logic: one READ cycle per register, then hold in SEND until accepted.
   always_comb begin
      stateNext = state;
      idxNext   = idx;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stateNext = READ;
               idxNext   = firstIdx;
            end
         end
         READ: begin
            stateNext = SEND;
            capture   = 1'b1;
         end
         SEND: begin
            if (out_ready) begin
               if (idx == lastIdx) begin
                  stateNext = DONE;
               end else begin
                  idxNext   = idx + 5'd1;
                  stateNext = READ;
               end
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, index and the captured beat; the beat registers only load in READ so they
   // stay frozen for the whole SEND phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         out_index <= '0;
         out_data  <= '0;
      end else begin
         state <= stateNext;
         idx   <= idxNext;
         if (capture) begin
            out_index <= idx;
            out_data  <= rd_data;
         end
      end
   end

   // All outputs decode registered state, so out_ready never reaches them combinationally.
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign out_valid = (state == SEND);
   assign rd_addr   = idx;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: three instances (full range, 8..15, 31..31) checked every cycle
// against a cycle-level behavioural model plus hand-computed dump scenarios.
module tb_regfile_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  start;
   logic [2:0]  outReady;
   logic [2:0]  busy;
   logic [2:0]  done;
   logic [2:0]  outValid;
   logic [4:0]  rdAddr   [3];
   logic [4:0]  outIndex [3];
   logic [31:0] rdData   [3];
   logic [31:0] outData  [3];
   logic [31:0] regs     [32];

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int doneCount [3] = '{0, 0, 0};
   bit checkEnable = 1'b0;

   logic [36:0] gotQ0 [$];
   logic [36:0] gotQ1 [$];
   logic [36:0] gotQ2 [$];
   int          cycQ2 [$];

   bit          mActive  [3];
   bit          mReading [3];
   bit          mShowing [3];
   bit          mDoneCyc [3];
   logic [4:0]  mIdx     [3];
   logic [31:0] mData    [3];

   always #5 clk = ~clk;

   regfile_dump #(.FIRST_REG(0), .LAST_REG(31)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .rd_addr(rdAddr[0]), .rd_data(rdData[0]), .out_valid(outValid[0]),
      .out_ready(outReady[0]), .out_index(outIndex[0]), .out_data(outData[0])
   );

   regfile_dump #(.FIRST_REG(8), .LAST_REG(15)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .rd_addr(rdAddr[1]), .rd_data(rdData[1]), .out_valid(outValid[1]),
      .out_ready(outReady[1]), .out_index(outIndex[1]), .out_data(outData[1])
   );

   regfile_dump #(.FIRST_REG(31), .LAST_REG(31)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .rd_addr(rdAddr[2]), .rd_data(rdData[2]), .out_valid(outValid[2]),
      .out_ready(outReady[2]), .out_index(outIndex[2]), .out_data(outData[2])
   );

   assign rdData[0] = regs[rdAddr[0]];
   assign rdData[1] = regs[rdAddr[1]];
   assign rdData[2] = regs[rdAddr[2]];

   function automatic logic [4:0] firstOf(input int k);
      case (k)
         0:       return 5'd0;
         1:       return 5'd8;
         default: return 5'd31;
      endcase
   endfunction

   function automatic logic [4:0] lastOf(input int k);
      case (k)
         0:       return 5'd31;
         1:       return 5'd15;
         default: return 5'd31;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] s, input logic [2:0] r, input logic rs);
      start    = s;
      outReady = r;
      rst      = rs;
      @(negedge clk);
   endtask

   task automatic pulseStart(input int k, output int edgeAt);
      start[k] = 1'b1;
      @(negedge clk);
      edgeAt   = cycle;
      start[k] = 1'b0;
   endtask

   // mode 0: valid beat with index want; mode 1: any valid beat; otherwise: done pulse.
   task automatic waitCond(input int k, input int mode, input logic [4:0] want, input string name);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 400 && !hit; n++) begin
         @(negedge clk);
         case (mode)
            0:       hit = outValid[k] && (outIndex[k] == want);
            1:       hit = outValid[k];
            default: hit = done[k];
         endcase
      end
      if (!hit) checkOutput({name, "Timeout"}, 0, 1);
   endtask

   // Dump model: a dump is one read cycle per register, a presentation that lasts until
   // accepted, and a single done cycle after the last register.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            mActive[k]  = 1'b0;
            mReading[k] = 1'b0;
            mShowing[k] = 1'b0;
            mDoneCyc[k] = 1'b0;
            mIdx[k]     = 5'd0;
            mData[k]    = 32'd0;
         end else if (mDoneCyc[k]) begin
            mDoneCyc[k] = 1'b0;
            mActive[k]  = 1'b0;
         end else if (!mActive[k]) begin
            if (start[k]) begin
               mActive[k]  = 1'b1;
               mReading[k] = 1'b1;
               mIdx[k]     = firstOf(k);
            end
         end else if (mReading[k]) begin
            mReading[k] = 1'b0;
            mShowing[k] = 1'b1;
            mData[k]    = regs[mIdx[k]];
         end else if (mShowing[k] && outReady[k]) begin
            mShowing[k] = 1'b0;
            if (mIdx[k] == lastOf(k)) begin
               mDoneCyc[k] = 1'b1;
            end else begin
               mIdx[k]     = mIdx[k] + 5'd1;
               mReading[k] = 1'b1;
            end
         end
      end
   end

   // Accepted-beat monitor and cycle counter.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (done[k]) doneCount[k]++;
         if (!rst && outValid[k] && outReady[k]) begin
            case (k)
               0: gotQ0.push_back({outIndex[k], outData[k]});
               1: gotQ1.push_back({outIndex[k], outData[k]});
               default: begin
                  gotQ2.push_back({outIndex[k], outData[k]});
                  cycQ2.push_back(cycle);
               end
            endcase
         end
      end
      cycle++;
   end

   always @(negedge clk) begin
      if (checkEnable) begin
         for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("busy%0d", k), busy[k], mActive[k]);
            checkOutput($sformatf("done%0d", k), done[k], mDoneCyc[k]);
            checkOutput($sformatf("valid%0d", k), outValid[k], mShowing[k]);
            checkOutput($sformatf("rdAddr%0d", k), rdAddr[k], mIdx[k]);
            if (mShowing[k]) begin
               checkOutput($sformatf("index%0d", k), outIndex[k], mIdx[k]);
               checkOutput($sformatf("data%0d", k), outData[k], mData[k]);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sEdge;
      int tmp;
      int d0;
      for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
      start    = 3'b000;
      outReady = 3'b111;
      rst      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("rstBusy%0d", k), busy[k], 0);
         checkOutput($sformatf("rstDone%0d", k), done[k], 0);
         checkOutput($sformatf("rstValid%0d", k), outValid[k], 0);
         checkOutput($sformatf("rstAddr%0d", k), rdAddr[k], 0);
         checkOutput($sformatf("rstIndex%0d", k), outIndex[k], 0);
         checkOutput($sformatf("rstData%0d", k), outData[k], 0);
      end
      checkEnable = 1'b1;

      for (int n = 0; n < 10; n++) applyStimulus(3'b000, 3'b111, 1'b0);
      checkOutput("idleBeats", gotQ0.size() + gotQ1.size() + gotQ2.size(), 0);

      // Full dump with out_ready tied high.
      gotQ0.delete();
      pulseStart(0, sEdge);
      waitCond(0, 1, 5'd0, "fullFirst");
      checkOutput("firstValidLatency", cycle - sEdge, 1);
      waitCond(0, 2, 5'd0, "fullDone");
      checkOutput("doneLatency", cycle - sEdge, 64);
      @(negedge clk);
      checkOutput("busyAfterDone", busy[0], 0);
      checkOutput("fullBeatCount", gotQ0.size(), 32);
      for (int i = 0; i < 32 && i < gotQ0.size(); i++)
         checkOutput($sformatf("fullBeat%0d", i), gotQ0[i], {5'(i), 32'hA000_0000 + 32'(i)});

      // Backpressure on beat 3.
      gotQ0.delete();
      pulseStart(0, sEdge);
      waitCond(0, 0, 5'd3, "bpBeat3");
      outReady[0] = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checkOutput("bpValid", outValid[0], 1);
         checkOutput("bpIndex", outIndex[0], 3);
         checkOutput("bpData", outData[0], 32'hA000_0003);
      end
      outReady[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("bpNextValid", outValid[0], 1);
      checkOutput("bpNextIndex", outIndex[0], 4);
      waitCond(0, 2, 5'd0, "bpDone");
      checkOutput("bpBeatCount", gotQ0.size(), 32);
      for (int i = 0; i < 32 && i < gotQ0.size(); i++)
         checkOutput($sformatf("bpBeat%0d", i), gotQ0[i], {5'(i), 32'hA000_0000 + 32'(i)});

      // Sub-range dump with a start pulse during beat 5 (index 12).
      gotQ1.delete();
      d0 = doneCount[1];
      pulseStart(1, sEdge);
      waitCond(1, 0, 5'd12, "rangeBeat5");
      pulseStart(1, tmp);
      waitCond(1, 2, 5'd0, "rangeDone");
      repeat (3) @(negedge clk);
      checkOutput("rangeBeatCount", gotQ1.size(), 8);
      for (int i = 0; i < 8 && i < gotQ1.size(); i++)
         checkOutput($sformatf("rangeBeat%0d", i), gotQ1[i], {5'(8 + i), 32'hA000_0008 + 32'(i)});
      checkOutput("rangeDoneCount", doneCount[1] - d0, 1);
      checkOutput("rangeBusyAfter", busy[1], 0);

      // Reset during SEND of beat 10, then restart from the first register.
      d0 = doneCount[0];
      pulseStart(0, sEdge);
      waitCond(0, 0, 5'd10, "rstBeat10");
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midRstValid", outValid[0], 0);
      checkOutput("midRstBusy", busy[0], 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("midRstNoDone", doneCount[0] - d0, 0);
      pulseStart(0, sEdge);
      waitCond(0, 1, 5'd0, "restartFirst");
      checkOutput("restartIndex", outIndex[0], 0);
      waitCond(0, 2, 5'd0, "restartDone");
      @(negedge clk);

      // Random traffic on all three instances with fresh register contents.
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      for (int n = 0; n < 1500; n++) begin
         logic [2:0] s;
         logic [2:0] r;
         for (int k = 0; k < 3; k++) begin
            s[k] = ($urandom_range(0, 7) == 0);
            r[k] = ($urandom_range(0, 3) != 0);
         end
         applyStimulus(s, r, $urandom_range(0, 249) == 0);
      end
      for (int n = 0; n < 80; n++) applyStimulus(3'b000, 3'b111, 1'b0);

      // Single-register range with start held high: a beat every four cycles.
      regs[31] = 32'hDEAD_BEEF;
      gotQ2.delete();
      cycQ2.delete();
      for (int n = 0; n < 14; n++) applyStimulus(3'b100, 3'b111, 1'b0);
      for (int n = 0; n < 8; n++) applyStimulus(3'b000, 3'b111, 1'b0);
      checkOutput("singleBeatCount", gotQ2.size(), 4);
      for (int i = 0; i < gotQ2.size(); i++)
         checkOutput($sformatf("singleBeat%0d", i), gotQ2[i], {5'd31, 32'hDEAD_BEEF});
      for (int i = 1; i < cycQ2.size(); i++)
         checkOutput($sformatf("singleSpacing%0d", i), cycQ2[i] - cycQ2[i-1], 4);

      checkEnable = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
